dma_channel_arbiter: RTL and testbench

//  Shares one DMA transfer engine between NUM_CH requesting channels.

---
 rtl/dma_channel_arbiter.sv | 144 ++++++++++++++
 tb/tb_dma_channel_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_arbiter.sv
// Shares one DMA engine among NUM_CH channels: priority arbitration with
// round-robin tie-break, start/done handshake and a BUSY-state watchdog.
module dma_channel_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH),
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   ch_req,
   input  logic [NUM_CH-1:0]   ch_en,
   input  logic [2*NUM_CH-1:0] ch_prio,
   input  logic [CNT_W-1:0]    timeout_cyc,
   input  logic                eng_done,
   input  logic                eng_err,
   output logic                eng_start,
   output logic                eng_abort,
   output logic [CH_W-1:0]     eng_ch,
   output logic [NUM_CH-1:0]   ch_grant,
   output logic [NUM_CH-1:0]   ch_done,
   output logic [NUM_CH-1:0]   ch_err,
   output logic                arb_busy,
   output logic                timeout_flag
);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, DONE} state_t;

   localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

   state_t            state, state_d;
   logic [CH_W-1:0]   rr_ptr, rr_ptr_d;
   logic [CH_W-1:0]   win, eng_ch_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [NUM_CH-1:0] valid, grant_d, done_d, err_d;
   logic [1:0]        max_p;
   logic              any_valid, found;
   logic              start_d, abort_d, tflag_d;

   assign valid = ch_req & ch_en;

   // Pass 1 finds the top priority; pass 2 walks from rr_ptr+1 for the tie.
   always_comb begin
      max_p     = 2'd0;
      any_valid = 1'b0;
      win       = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (valid[i] && (!any_valid || ch_prio[2*i +: 2] > max_p)) begin
            max_p     = ch_prio[2*i +: 2];
            any_valid = 1'b1;
         end
      end
      for (int k = 1; k <= NUM_CH; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_CH;
         if (!found && valid[idx] && ch_prio[2*idx +: 2] == max_p) begin
            win   = CH_W'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state;
      rr_ptr_d = rr_ptr;
      eng_ch_d = eng_ch;
      grant_d  = ch_grant;
      cnt_d    = cnt;
      start_d  = 1'b0;
      abort_d  = 1'b0;
      tflag_d  = 1'b0;
      done_d   = '0;
      err_d    = '0;
      unique case (state)
         IDLE: begin
            if (any_valid) begin
               eng_ch_d = win;
               grant_d  = ONE << win;
               start_d  = 1'b1;
               state_d  = GRANT;
            end
         end
         GRANT: begin
            cnt_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            if (eng_done) begin
               done_d  = ch_grant;
               state_d = DONE;
            end else if (eng_err) begin
               err_d   = ch_grant;
               state_d = DONE;
            end else if (!ch_en[eng_ch]) begin
               abort_d = 1'b1;
               err_d   = ch_grant;
               state_d = DONE;
            end else if (timeout_cyc != '0 && cnt == timeout_cyc) begin
               tflag_d = 1'b1;
               abort_d = 1'b1;
               err_d   = ch_grant;
               state_d = DONE;
            end else if (cnt != '1) begin
               cnt_d = cnt + 1'b1;
            end
         end
         DONE: begin
            rr_ptr_d = eng_ch;
            grant_d  = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= CH_W'(NUM_CH - 1);
         cnt          <= '0;
         eng_start    <= 1'b0;
         eng_abort    <= 1'b0;
         eng_ch       <= '0;
         ch_grant     <= '0;
         ch_done      <= '0;
         ch_err       <= '0;
         arb_busy     <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         state        <= state_d;
         rr_ptr       <= rr_ptr_d;
         cnt          <= cnt_d;
         eng_start    <= start_d;
         eng_abort    <= abort_d;
         eng_ch       <= eng_ch_d;
         ch_grant     <= grant_d;
         ch_done      <= done_d;
         ch_err       <= err_d;
         arb_busy     <= (state_d != IDLE);
         timeout_flag <= tflag_d;
      end
   end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboard bench for dma_channel_arbiter: directed transfers push expected
// grants/results; a negedge monitor pops and compares on every DUT event.
module tb_dma_channel_arbiter;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam int CNT_W  = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NUM_CH-1:0]   ch_req;
   logic [NUM_CH-1:0]   ch_en;
   logic [2*NUM_CH-1:0] ch_prio;
   logic [CNT_W-1:0]    timeout_cyc;
   logic                eng_done;
   logic                eng_err;
   logic                eng_start;
   logic                eng_abort;
   logic [CH_W-1:0]     eng_ch;
   logic [NUM_CH-1:0]   ch_grant;
   logic [NUM_CH-1:0]   ch_done;
   logic [NUM_CH-1:0]   ch_err;
   logic                arb_busy;
   logic                timeout_flag;

   always #5 clk = ~clk;

   dma_channel_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ch_req       (ch_req),
      .ch_en        (ch_en),
      .ch_prio      (ch_prio),
      .timeout_cyc  (timeout_cyc),
      .eng_done     (eng_done),
      .eng_err      (eng_err),
      .eng_start    (eng_start),
      .eng_abort    (eng_abort),
      .eng_ch       (eng_ch),
      .ch_grant     (ch_grant),
      .ch_done      (ch_done),
      .ch_err       (ch_err),
      .arb_busy     (arb_busy),
      .timeout_flag (timeout_flag)
   );

   typedef struct {
      int ch;
      bit ok;
      bit abort;
      bit tflag;
   } res_t;

   int   exp_grant_q[$];
   res_t exp_res_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor
   int   mon_g;
   res_t mon_r;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (eng_start) begin
            if (exp_grant_q.size() == 0) begin
               check("unexpected_start", 32'd1, 32'd0);
            end else begin
               mon_g = exp_grant_q.pop_front();
               check("grant_ch", 32'(eng_ch), 32'(mon_g));
               check("grant_onehot", 32'(ch_grant), 32'(1) << mon_g);
               check("busy_at_start", 32'(arb_busy), 32'd1);
            end
         end
         if (|ch_done || |ch_err) begin
            if (exp_res_q.size() == 0) begin
               check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
               mon_r = exp_res_q.pop_front();
               check("done_vec", 32'(ch_done),
                     mon_r.ok ? (32'(1) << mon_r.ch) : 32'd0);
               check("err_vec", 32'(ch_err),
                     mon_r.ok ? 32'd0 : (32'(1) << mon_r.ch));
               check("abort", 32'(eng_abort), 32'(mon_r.abort));
               check("timeout_flag", 32'(timeout_flag), 32'(mon_r.tflag));
            end
         end else if (eng_abort || timeout_flag) begin
            check("stray_abort", {30'd0, eng_abort, timeout_flag}, 32'd0);
         end
      end
   end

   task automatic wait_start(output bit ok);
      int n;
      n = 0;
      while (!eng_start && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = eng_start;
      if (!ok) check("start_wait_expired", 32'd0, 32'd1);
   endtask

   // kind: 0 done, 1 engine error, 2 no response, 3 drop ch_en
   task automatic run_xfer(input int ch, input int kind, input int lat,
                           input bit abort, input bit tflag);
      res_t r;
      bit   ok;
      int   n;
      exp_grant_q.push_back(ch);
      r.ch    = ch;
      r.ok    = (kind == 0);
      r.abort = abort;
      r.tflag = tflag;
      exp_res_q.push_back(r);
      wait_start(ok);
      if (!ok) return;
      repeat (lat) @(negedge clk);
      case (kind)
         0:       eng_done = 1'b1;
         1:       eng_err = 1'b1;
         3:       ch_en[ch] = 1'b0;
         default: ;
      endcase
      n = lat;
      do begin
         @(negedge clk);
         n++;
         eng_done = 1'b0;
         eng_err  = 1'b0;
      end while (!(|ch_done || |ch_err) && n < lat + 60);
      check("pulse_latency", 32'(n), 32'(lat + 1));
      if (kind == 3) ch_en[ch] = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench time limit");
   end

   initial begin
      bit ok;
      int order[5];
      rst_n       = 1'b0;
      ch_req      = '0;
      ch_en       = '1;
      ch_prio     = '0;
      timeout_cyc = '0;
      eng_done    = 1'b0;
      eng_err     = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({eng_start, eng_abort, eng_ch, ch_grant,
            ch_done, ch_err, arb_busy, timeout_flag}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single channel, done 4 cycles after start
      ch_prio = 8'b00_00_00_01;
      ch_req  = 4'b0001;
      run_xfer(0, 0, 4, 1'b0, 1'b0);
      ch_req = '0;
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(arb_busy), 32'd0);
      check("idle_grant", 32'(ch_grant), 32'd0);

      // Round robin among equal priorities
      do_reset();
      ch_prio = 8'hAA;
      ch_req  = 4'hF;
      order   = '{0, 1, 2, 3, 0};
      foreach (order[i]) run_xfer(order[i], 0, 1, 1'b0, 1'b0);
      ch_req = '0;

      // Engine pulses outside BUSY are ignored
      repeat (2) @(negedge clk);
      eng_done = 1'b1;
      eng_err  = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      eng_err  = 1'b0;
      repeat (3) @(negedge clk);
      check("ignored_eng_busy", 32'(arb_busy), 32'd0);

      // Strict priority: ch2 (3) starves ch1 (1)
      ch_prio = 8'b00_11_01_00;
      ch_req  = 4'b0110;
      repeat (3) run_xfer(2, 0, 1, 1'b0, 1'b0);
      ch_req = 4'b0010;
      run_xfer(1, 0, 2, 1'b0, 1'b0);
      ch_req = '0;

      // Watchdog at T=5, then a normal grant
      timeout_cyc = 16'd5;
      ch_prio     = 8'b11_00_00_00;
      ch_req      = 4'b1000;
      run_xfer(3, 2, 6, 1'b1, 1'b1);
      ch_req = 4'b0001;
      run_xfer(0, 0, 2, 1'b0, 1'b0);
      ch_req = '0;

      // Channel disabled mid-transfer
      timeout_cyc = '0;
      ch_req      = 4'b0100;
      run_xfer(2, 3, 2, 1'b1, 1'b0);
      ch_req = '0;

      // Done coincident with timeout: done wins
      timeout_cyc = 16'd3;
      ch_req      = 4'b0100;
      run_xfer(2, 0, 4, 1'b0, 1'b0);
      ch_req      = '0;
      timeout_cyc = '0;

      // Disabled channel skipped; engine error path
      ch_prio = '0;
      ch_en   = 4'b1110;
      ch_req  = 4'b0011;
      run_xfer(1, 0, 1, 1'b0, 1'b0);
      ch_req = '0;
      ch_en  = '1;
      ch_req = 4'b1000;
      run_xfer(3, 1, 2, 1'b0, 1'b0);
      ch_req = '0;

      // Reset mid-transfer
      repeat (2) @(negedge clk);
      ch_req = 4'b0010;
      exp_grant_q.push_back(1);
      wait_start(ok);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", 32'({eng_start, eng_abort, eng_ch, ch_grant,
            ch_done, ch_err, arb_busy, timeout_flag}), 32'd0);
      ch_req = 4'b0011;
      @(negedge clk);
      rst_n = 1'b1;
      run_xfer(0, 0, 1, 1'b0, 1'b0);
      ch_req = '0;

      repeat (5) @(negedge clk);
      check("grant_q_empty", 32'(exp_grant_q.size()), 32'd0);
      check("res_q_empty", 32'(exp_res_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
